// File: rtl/rmem_read_engine.sv
// rtl/rmem_read_engine.sv - single-word OBI read engine for the coprocessor read handshake (optional timeout: RMEM_READ_TIMEOUT_EN)
module rmem_read_engine #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [31:0] addr_i,
   output logic [31:0] rdata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        busy_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RVALID,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

`ifdef RMEM_READ_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
`endif

   // Next-state and result capture; results only change on the way into DONE
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef RMEM_READ_TIMEOUT_EN
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      // A response left over from a timed-out read is dropped when it finally shows up
      if (pend_q && data_rvalid_i && (state_q == IDLE || state_q == REQ)) begin
         pend_d = 1'b0;
      end
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (addr_i[1:0] == 2'b00) begin
                  addr_d  = addr_i;
                  state_d = REQ;
               end else begin
                  rdata_d = ERR_DATA;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         REQ: begin
            if (data_gnt_i) begin
               state_d = WAIT_RVALID;
`ifdef RMEM_READ_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               rdata_d = data_err_i ? ERR_DATA : data_rdata_i;
               err_d   = data_err_i;
               state_d = DONE;
`ifdef RMEM_READ_TIMEOUT_EN
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = ERR_DATA;
               err_d   = 1'b1;
               pend_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef RMEM_READ_TIMEOUT_EN
         cnt_q   <= '0;
         pend_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef RMEM_READ_TIMEOUT_EN
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
`endif
      end
   end

   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign done_o      = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign data_req_o  = (state_q == REQ);
   assign data_addr_o = addr_q;
   assign data_we_o   = 1'b0;
   assign data_be_o   = 4'hF;

endmodule

// File: tb/tb_rmem_read_engine.sv
// tb/tb_rmem_read_engine.sv - randomized self-checking bench for rmem_read_engine
module tb_rmem_read_engine;

   localparam int unsigned TMO = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] rdata_o;
   logic        done_o, err_o, busy_o, data_req_o, data_we_o;
   logic        data_gnt_i = 1'b0;
   logic [31:0] data_addr_o;
   logic [3:0]  data_be_o;
   logic        data_rvalid_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   logic        data_err_i = 1'b0;

   int vec = 0;
   int errs = 0;

   // Reference state: result of the last completed transaction
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;

   rmem_read_engine #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRD)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i),
      .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_rvalid_i(data_rvalid_i),
      .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One read: start in cycle 0, grant g cycles after the request rises,
   // response r cycles after entering the wait. noise adds re-issued starts
   // while busy and illegal responses during the request phase.
   task automatic do_read(input logic [31:0] a, input int g, input int r,
                          input logic [31:0] d, input logic e, input bit noise);
      bit          aligned;
      bit          to;
      int          done_cyc;
      logic [31:0] new_rd;
      logic        new_err;
      aligned = (a[1:0] == 2'b00);
      to = 1'b0;
`ifdef RMEM_READ_TIMEOUT_EN
      to = aligned && (r >= int'(TMO));
`endif
      if (!aligned)  done_cyc = 1;
      else if (to)   done_cyc = 2 + g + int'(TMO);
      else           done_cyc = 3 + g + r;
      new_err = !aligned || e || to;
      new_rd  = new_err ? ERRD : d;
      for (int k = 0; k <= done_cyc + 1; k++) begin
         tick();
         vec++;
         if (done_o !== (k == done_cyc)) begin
            errs++;
            $display("FAIL done k=%0d got %b exp %b", k, done_o, (k == done_cyc));
         end
         vec++;
         if (busy_o !== (k >= 1 && k <= done_cyc)) begin
            errs++;
            $display("FAIL busy k=%0d got %b exp %b", k, busy_o, (k >= 1 && k <= done_cyc));
         end
         vec++;
         if (data_req_o !== (aligned && k >= 1 && k <= 1 + g)) begin
            errs++;
            $display("FAIL req k=%0d got %b exp %b", k, data_req_o, (aligned && k >= 1 && k <= 1 + g));
         end
         if (aligned && k >= 1 && k <= 1 + g) begin
            vec++;
            if (data_addr_o !== a) begin
               errs++;
               $display("FAIL addr k=%0d got %h exp %h", k, data_addr_o, a);
            end
         end
         vec++;
         if (rdata_o !== ((k >= done_cyc) ? new_rd : exp_rdata)) begin
            errs++;
            $display("FAIL rdata k=%0d got %h exp %h", k, rdata_o, (k >= done_cyc) ? new_rd : exp_rdata);
         end
         vec++;
         if (err_o !== ((k >= done_cyc) ? new_err : exp_err)) begin
            errs++;
            $display("FAIL err k=%0d got %b exp %b", k, err_o, (k >= done_cyc) ? new_err : exp_err);
         end
         // Drive inputs for cycle k
         start_i       = (k == 0) || (noise && k >= 1 && k <= done_cyc && $urandom_range(0, 1) == 1);
         addr_i        = (k == 0) ? a : $urandom;
         data_gnt_i    = aligned && (k == 1 + g);
         data_rvalid_i = aligned && !to && (k == 2 + g + r);
         data_rdata_i  = data_rvalid_i ? d : $urandom;
         data_err_i    = data_rvalid_i ? e : 1'b0;
         if (noise && aligned && k >= 1 && k <= 1 + g && $urandom_range(0, 1) == 1) begin
            data_rvalid_i = 1'b1;
            data_err_i    = 1'($urandom_range(0, 1));
         end
      end
      start_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      exp_rdata = new_rd;
      exp_err   = new_err;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      tick(); tick();
      vec++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h exp 0", rdata_o); end
      vec++; if (err_o !== 1'b0) begin errs++; $display("FAIL rst_err got %b exp 0", err_o); end
      vec++; if (done_o !== 1'b0) begin errs++; $display("FAIL rst_done got %b exp 0", done_o); end
      vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy_o); end
      vec++; if (data_req_o !== 1'b0) begin errs++; $display("FAIL rst_req got %b exp 0", data_req_o); end
      vec++; if (data_addr_o !== 32'h0) begin errs++; $display("FAIL rst_addr got %h exp 0", data_addr_o); end
      vec++; if (data_we_o !== 1'b0) begin errs++; $display("FAIL we got %b exp 0", data_we_o); end
      vec++; if (data_be_o !== 4'hF) begin errs++; $display("FAIL be got %h exp f", data_be_o); end
      rst_ni = 1'b1;
      exp_rdata = '0;
      exp_err   = 1'b0;
   endtask

   task automatic test_basic();
      do_read(32'h0000_1000, 0, 0, 32'hCAFE_0001, 1'b0, 1'b0);
   endtask

   task automatic test_gnt_delay();
      do_read(32'h0000_2000, 5, 0, 32'h1234_5678, 1'b0, 1'b0);
   endtask

   task automatic test_misaligned();
      do_read(32'h0000_1002, 0, 0, 32'h0, 1'b0, 1'b0);
      do_read(32'h0000_1001, 0, 0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_bus_err();
      do_read(32'h0000_3000, 1, 1, 32'h5555_AAAA, 1'b1, 1'b0);
      do_read(32'h0000_3004, 0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
   endtask

   task automatic test_ignore_start();
      do_read(32'h0000_4000, 2, 3, 32'hA5A5_0001, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      tick();
      start_i = 1'b1; addr_i = 32'h0000_5000;
      tick();
      vec++; if (data_req_o !== 1'b1) begin errs++; $display("FAIL mid_req got %b exp 1", data_req_o); end
      start_i = 1'b0; rst_ni = 1'b0;
      tick();
      vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL mid_busy got %b exp 0", busy_o); end
      vec++; if (data_req_o !== 1'b0) begin errs++; $display("FAIL mid_req0 got %b exp 0", data_req_o); end
      vec++; if (data_addr_o !== 32'h0) begin errs++; $display("FAIL mid_addr got %h exp 0", data_addr_o); end
      vec++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL mid_rdata got %h exp 0", rdata_o); end
      vec++; if (err_o !== 1'b0) begin errs++; $display("FAIL mid_err got %b exp 0", err_o); end
      rst_ni = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = $urandom;
      for (int i = 0; i < 4; i++) begin
         tick();
         data_rvalid_i = 1'b0;
         vec++; if (done_o !== 1'b0) begin errs++; $display("FAIL late_rvalid_done i=%0d got %b exp 0", i, done_o); end
         vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL late_rvalid_busy i=%0d got %b exp 0", i, busy_o); end
      end
      exp_rdata = '0;
      exp_err   = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = {16'h0, 16'($urandom)};
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_read(a, $urandom_range(0, 4), $urandom_range(0, 2), $urandom,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
   endtask

`ifdef RMEM_READ_TIMEOUT_EN
   task automatic test_timeout();
      do_read(32'h0000_6000, 1, TMO, 32'h0, 1'b0, 1'b0);
      tick();
      data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777;
      tick();
      data_rvalid_i = 1'b0;
      vec++; if (done_o !== 1'b0) begin errs++; $display("FAIL stray_done got %b exp 0", done_o); end
      vec++; if (rdata_o !== ERRD) begin errs++; $display("FAIL stray_rdata got %h exp %h", rdata_o, ERRD); end
      do_read(32'h0000_6004, 0, TMO - 1, 32'h600D_0004, 1'b0, 1'b0);
      do_read(32'h0000_6008, 2, 0, 32'h600D_0008, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gnt_delay();
      test_misaligned();
      test_bus_err();
      test_ignore_start();
      test_reset_mid();
      test_random();
`ifdef RMEM_READ_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/rmem_read_engine.md
Name: rmem_read_engine

Overview:
- Memory-side implementation of the coprocessor read handshake (read_mod modport role).
- On a start pulse from the coprocessor, the block captures the address from source register 0 and performs one 32-bit read on the core's OBI data port.
- It returns the word on rdata_o and pulses done_o.
- Sits between the coprocessor control (coprog) and the data-memory bus.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT_RVALID before abort. Used only with the optional feature. Must be >= 2.
- ERR_DATA, 32'hDEAD_BEEF, value driven on rdata_o after a bus error, misalignment or timeout.

Ports:
- clk_i  input  1  clock, all logic rising-edge.
- rst_ni  input  1  synchronous active-low reset.
- start_i  input  1  read request pulse from coprocessor. Sampled only in IDLE.
- addr_i  input  32  byte address (source register 0). Captured when start_i is accepted.
- rdata_o  output  32  read data. Registered and held until the next accepted start.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  status of last transaction. Registered and held like rdata_o.
- busy_o  output  1  high in any state other than IDLE.
- data_req_o  output  1  OBI request.
- data_gnt_i  input  1  OBI grant.
- data_addr_o  output  32  OBI address. Word-aligned, held stable while data_req_o=1.
- data_we_o  output  1  constant 0.
- data_be_o  output  4  constant 4'hF.
- data_rvalid_i  input  1  OBI response valid.
- data_rdata_i  input  32  OBI response data.
- data_err_i  input  1  OBI response error, valid with data_rvalid_i.

Behaviour:
- Reset (rst_ni=0 at clock edge), from any state including mid-transaction:
  - state=IDLE.
  - rdata_o=0, done_o=0, err_o=0, busy_o=0, data_req_o=0, data_addr_o=0, timeout counter=0.
  - Any outstanding OBI response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RVALID, DONE.
- IDLE:
  - start_i=1 and addr_i[1:0]==0: latch addr_i, go to REQ.
  - start_i=1 and addr_i[1:0]!=0: no bus access. Set rdata_o=ERR_DATA, err_o=1, go to DONE.
- REQ:
  - data_req_o=1, data_addr_o=latched address.
  - data_gnt_i=1: go to WAIT_RVALID. Otherwise stay with request and address held.
  - data_rvalid_i in REQ is illegal per OBI and is ignored.
- WAIT_RVALID:
  - data_req_o=0.
  - data_rvalid_i=1: rdata_o = data_err_i ? ERR_DATA : data_rdata_i; err_o=data_err_i; go to DONE.
- DONE:
  - done_o=1 for exactly this one cycle, then IDLE.
  - start_i in DONE is ignored; the coprocessor must re-issue it.
- start_i while busy_o=1 is ignored. No queueing.
- rdata_o and err_o change only on the transition into DONE. They are stable between done pulses.
- Minimum latency (start at cycle N, gnt at N+1, rvalid at N+2): done_o at N+3.
- Misaligned latency: done_o at N+1.

Optional Feature:
- Macro: RMEM_READ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RVALID and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES without data_rvalid_i: rdata_o=ERR_DATA, err_o=1, go to DONE.
  - Then a single stray data_rvalid_i is absorbed (dropped) in IDLE/REQ via a one-bit pending flag, cleared by reset.
  - data_rvalid_i on the exact cycle the counter hits the limit takes priority: normal completion.
- Not defined:
  - No counter or flag is synthesised.
  - WAIT_RVALID waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then start_i=1, addr_i=32'h0000_1000; gnt same cycle as req; rvalid next cycle with rdata 32'hCAFE_0001 -> data_addr_o=32'h1000, rdata_o=32'hCAFE_0001, err_o=0, done_o one pulse at start+3.
- Grant delayed 5 cycles -> data_req_o high and data_addr_o stable for 6 cycles; done_o at start+8.
- start_i with addr_i=32'h0000_1002 -> no data_req_o ever; done_o at start+1; rdata_o=32'hDEAD_BEEF; err_o=1.
- rvalid with data_err_i=1 -> rdata_o=32'hDEAD_BEEF, err_o=1. Next good read clears err_o=0.
- start_i pulsed again during WAIT_RVALID, and rst_ni=0 asserted in REQ -> second start has no effect; after reset all outputs are 0 and state is IDLE; a late rvalid produces no done_o.
- With RMEM_READ_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt but no rvalid -> done_o 4 cycles after entering WAIT_RVALID; err_o=1; a late rvalid is dropped and the next read returns correct data.
